// File: rtl/mem_ctrl_if.sv
// Memory bus between the MEM-stage controller (master) and the data memory (slave).
// Strobe and ready are active-low.
interface mem_ctrl_if;
   logic        bus_as_;
   logic        bus_rw;
   logic [29:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wr_data;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_;

   modport master (
      output bus_as_, bus_rw, bus_addr, bus_be, bus_wr_data,
      input  bus_rd_data, bus_rdy_
   );

   modport slave (
      input  bus_as_, bus_rw, bus_addr, bus_be, bus_wr_data,
      output bus_rd_data, bus_rdy_
   );
endinterface

// File: rtl/mem_ctrl.sv
// MEM-stage load/store controller: IDLE -> BUS -> DONE handshake with the data bus.
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_en,
   input  logic [3:0]  ex_mem_op,
   input  logic [31:0] ex_out,
   input  logic [31:0] ex_mem_wr_data,
   input  logic        stall,
   input  logic        flush,
   mem_ctrl_if.master  bus,
   output logic [31:0] out,
   output logic        miss_align,
   output logic        busy,
   output logic        bus_err
);
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
   state_t state_q, state_d;

   logic        is_byte, is_half, is_word;
   logic        is_load, is_store, acc;
   logic [3:0]  be_d;
   logic [31:0] wdat_d;
   logic [31:0] rd_buf;
   logic [3:0]  op_q;
   logic [1:0]  off_q;
   logic        discard_q;
   logic        tmo;

   function automatic logic [31:0] fmt(
      input logic [3:0]  op,
      input logic [1:0]  off,
      input logic [31:0] d
   );
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{off, 3'b000} +: 8];
      h = off[1] ? d[31:16] : d[15:0];
      case (op)
         OP_LB:   fmt = {{24{b[7]}}, b};
         OP_LBU:  fmt = {24'd0, b};
         OP_LH:   fmt = {{16{h[15]}}, h};
         OP_LHU:  fmt = {16'd0, h};
         default: fmt = d;
      endcase
   endfunction

   always_comb begin
      is_byte  = ex_mem_op inside {OP_LB, OP_LBU, OP_SB};
      is_half  = ex_mem_op inside {OP_LH, OP_LHU, OP_SH};
      is_word  = ex_mem_op inside {OP_LW, OP_SW};
      is_load  = ex_mem_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
      is_store = ex_mem_op inside {OP_SB, OP_SH, OP_SW};
   end

   assign miss_align = ex_en &
      ((is_half & ex_out[0]) | (is_word & (|ex_out[1:0])));
   assign acc = ex_en & (is_load | is_store) & ~miss_align & ~flush;

   always_comb begin
      be_d   = 4'b0000;
      wdat_d = ex_mem_wr_data;
      unique case (1'b1)
         is_byte: begin
            be_d   = 4'b0001 << ex_out[1:0];
            wdat_d = {4{ex_mem_wr_data[7:0]}};
         end
         is_half: begin
            be_d   = ex_out[1] ? 4'b1100 : 4'b0011;
            wdat_d = {2{ex_mem_wr_data[15:0]}};
         end
         is_word: be_d = 4'b1111;
         default: be_d = 4'b0000;
      endcase
   end

`ifdef MEM_BUS_TIMEOUT_EN
   logic [7:0] tmo_q;
   logic       err_q;

   // Fires on the 255th BUS cycle, the one that takes the counter to 255.
   assign tmo     = (tmo_q == 8'd254) & bus.bus_rdy_;
   assign bus_err = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         if (state_q == IDLE && acc)
            tmo_q <= 8'd0;
         else if (state_q == BUS)
            tmo_q <= tmo_q + 8'd1;
         if (state_q == BUS && state_d == DONE && tmo)
            err_q <= 1'b1;
         else if (state_q == DONE && state_d != DONE)
            err_q <= 1'b0;
      end
   end
`else
   assign tmo     = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      out     = 32'd0;
      case (state_q)
         IDLE: begin
            if (acc) begin
               state_d = BUS;
               busy    = 1'b1;
            end else if (!miss_align) begin
               out = ex_out;
            end
         end
         BUS: begin
            busy = 1'b1;
            if (!bus.bus_rdy_)
               state_d = (discard_q | flush) ? IDLE : DONE;
            else if (tmo)
               state_d = DONE;
         end
         DONE: begin
            if (bus.bus_rw && !bus_err)
               out = fmt(op_q, off_q, rd_buf);
            if (!stall)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         bus.bus_as_     <= 1'b1;
         bus.bus_rw      <= 1'b1;
         bus.bus_addr    <= 30'd0;
         bus.bus_be      <= 4'd0;
         bus.bus_wr_data <= 32'd0;
         rd_buf          <= 32'd0;
         discard_q       <= 1'b0;
         op_q            <= 4'd0;
         off_q           <= 2'd0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && acc) begin
            bus.bus_as_     <= 1'b0;
            bus.bus_rw      <= is_load;
            bus.bus_addr    <= ex_out[31:2];
            bus.bus_be      <= be_d;
            bus.bus_wr_data <= wdat_d;
            op_q            <= ex_mem_op;
            off_q           <= ex_out[1:0];
            discard_q       <= 1'b0;
         end
         if (state_q == BUS) begin
            if (!bus.bus_rdy_)
               rd_buf <= bus.bus_rd_data;
            if (state_d != BUS) begin
               bus.bus_as_ <= 1'b1;
               discard_q   <= 1'b0;
            end else if (flush) begin
               discard_q <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of load/store vectors plus
// misalignment, flush, reset-abort and optional timeout cases.
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        ex_en, stall, flush;
   logic [3:0]  op;
   logic [31:0] ex_out, wd;
   logic [31:0] out;
   logic        miss_align, busy, bus_err;
   int          checks = 0;
   int          failures = 0;

   mem_ctrl_if bus_if();

   mem_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .ex_en          (ex_en),
      .ex_mem_op      (op),
      .ex_out         (ex_out),
      .ex_mem_wr_data (wd),
      .stall          (stall),
      .flush          (flush),
      .bus            (bus_if.master),
      .out            (out),
      .miss_align     (miss_align),
      .busy           (busy),
      .bus_err        (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, wd, rd;
      int          waits;
      logic [31:0] res;
      logic [3:0]  be;
      logic [31:0] wdo;
      logic        rw;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input vec_t t, input int stall_n);
      logic [31:0] res = 32'd0;
      logic [31:0] wdo = 32'd0;
      logic [29:0] ad = 30'd0;
      logic [3:0]  be = 4'd0;
      logic        rw = 1'b0;
      int          busy_n = 0;
      int          bus_n = 0;
      bit          done = 1'b0;
      ex_en = 1'b1;
      op = t.op;
      ex_out = t.a;
      wd = t.wd;
      bus_if.bus_rd_data = t.rd;
      bus_if.bus_rdy_ = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         if (bus_if.bus_as_ == 1'b0) begin
            ad  = bus_if.bus_addr;
            be  = bus_if.bus_be;
            wdo = bus_if.bus_wr_data;
            rw  = bus_if.bus_rw;
            bus_n++;
            bus_if.bus_rdy_ = (bus_n > t.waits) ? 1'b0 : 1'b1;
         end else begin
            bus_if.bus_rdy_ = 1'b1;
         end
         #1;
         if (busy) busy_n++;
         else if (c > 0) begin
            done = 1'b1;
            res = out;
         end
         if (!done) tick();
      end
      bus_if.bus_rdy_ = 1'b1;
      check("done_reached", 32'(done), 32'd1);
      check("busy_cycles", busy_n, t.waits + 2);
      check("load_result", res, t.res);
      check("bus_be", 32'(be), 32'(t.be));
      check("bus_wr_data", wdo, t.wdo);
      check("bus_rw", 32'(rw), 32'(t.rw));
      check("bus_addr", 32'(ad), 32'(t.a[31:2]));
      stall = 1'b1;
      repeat (stall_n) begin
         tick();
         check("stall_hold_out", out, t.res);
         check("stall_hold_busy", 32'(busy), 32'd0);
      end
      stall = 1'b0;
      tick();
      ex_en = 1'b0;
      op = 4'd0;
      #1;
      check("idle_pass", out, t.a);
      check("idle_as", 32'(bus_if.bus_as_), 32'd1);
   endtask

   initial begin
      vecs[0] = '{4'd3, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                  32'hDEADBEEF, 4'b1111, 32'h0, 1'b1};
      vecs[1] = '{4'd1, 32'h103, 32'h0, 32'h80123456, 0,
                  32'hFFFFFF80, 4'b1000, 32'h0, 1'b1};
      vecs[2] = '{4'd4, 32'h103, 32'h0, 32'h80123456, 0,
                  32'h00000080, 4'b1000, 32'h0, 1'b1};
      vecs[3] = '{4'd7, 32'h102, 32'h0000ABCD, 32'h0, 1,
                  32'h0, 4'b1100, 32'hABCDABCD, 1'b0};
      vecs[4] = '{4'd2, 32'h102, 32'h0, 32'h80123456, 2,
                  32'hFFFF8012, 4'b1100, 32'h0, 1'b1};
      vecs[5] = '{4'd5, 32'h100, 32'h0, 32'h1234F00D, 0,
                  32'h0000F00D, 4'b0011, 32'h0, 1'b1};
      vecs[6] = '{4'd6, 32'h101, 32'h000000A5, 32'h0, 0,
                  32'h0, 4'b0010, 32'hA5A5A5A5, 1'b0};
      vecs[7] = '{4'd8, 32'h104, 32'h11223344, 32'h0, 1,
                  32'h0, 4'b1111, 32'h11223344, 1'b0};

      reset = 1'b1;
      ex_en = 1'b0; op = 4'd0; ex_out = 32'h55; wd = 32'd0;
      stall = 1'b0; flush = 1'b0;
      bus_if.bus_rdy_ = 1'b1;
      bus_if.bus_rd_data = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_as", 32'(bus_if.bus_as_), 32'd1);
      check("rst_rw", 32'(bus_if.bus_rw), 32'd1);
      check("rst_addr", 32'(bus_if.bus_addr), 32'd0);
      check("rst_be", 32'(bus_if.bus_be), 32'd0);
      check("rst_wdata", bus_if.bus_wr_data, 32'd0);
      check("rst_err", 32'(bus_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out", out, 32'h55);
      reset = 1'b0;
      tick();

      foreach (vecs[i]) run(vecs[i], i % 2);

      // invalid opcode is a NOP: passthrough
      ex_en = 1'b1; op = 4'd9; ex_out = 32'h1234;
      #1;
      check("nop_busy", 32'(busy), 32'd0);
      check("nop_out", out, 32'h1234);

      // misalignment
      op = 4'd3; ex_out = 32'h101;
      #1;
      check("mis_lw", 32'(miss_align), 32'd1);
      check("mis_out", out, 32'd0);
      check("mis_busy", 32'(busy), 32'd0);
      tick();
      check("mis_as", 32'(bus_if.bus_as_), 32'd1);
      check("mis_still_idle", 32'(busy), 32'd0);
      op = 4'd5; ex_out = 32'h101;
      #1;
      check("mis_lhu", 32'(miss_align), 32'd1);
      op = 4'd8; ex_out = 32'h102;
      #1;
      check("mis_sw", 32'(miss_align), 32'd1);
      op = 4'd7; ex_out = 32'h102;
      #1;
      check("mis_sh_ok", 32'(miss_align), 32'd0);
      op = 4'd1; ex_out = 32'h103;
      #1;
      check("mis_lb_ok", 32'(miss_align), 32'd0);
      ex_en = 1'b0; op = 4'd3; ex_out = 32'h101;
      #1;
      check("mis_no_en", 32'(miss_align), 32'd0);

      // flush in IDLE suppresses the access
      ex_en = 1'b1; op = 4'd3; ex_out = 32'h100; flush = 1'b1;
      #1;
      check("flush_idle_busy", 32'(busy), 32'd0);
      tick();
      check("flush_idle_as", 32'(bus_if.bus_as_), 32'd1);
      flush = 1'b0;

      // flush during BUS, ready three cycles late
      bus_if.bus_rd_data = 32'h12345678;
      ex_out = 32'h200;
      tick();
      check("fl_bus_as", 32'(bus_if.bus_as_), 32'd0);
      flush = 1'b1;
      #1;
      check("fl_bus_busy", 32'(busy), 32'd1);
      tick();
      flush = 1'b0; ex_en = 1'b0; ex_out = 32'd0;
      repeat (2) begin
         #1;
         check("fl_hold_busy", 32'(busy), 32'd1);
         tick();
      end
      bus_if.bus_rdy_ = 1'b0;
      #1;
      check("fl_rdy_busy", 32'(busy), 32'd1);
      tick();
      bus_if.bus_rdy_ = 1'b1;
      #1;
      check("fl_after_busy", 32'(busy), 32'd0);
      check("fl_after_out", out, 32'd0);
      check("fl_after_as", 32'(bus_if.bus_as_), 32'd1);
      tick();

      // reset in BUS abandons the cycle
      ex_en = 1'b1; op = 4'd3; ex_out = 32'h300;
      tick();
      ex_en = 1'b0; ex_out = 32'h77;
      check("rb_as", 32'(bus_if.bus_as_), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("rb_async_as", 32'(bus_if.bus_as_), 32'd1);
      check("rb_busy", 32'(busy), 32'd0);
      #2 reset = 1'b0;
      bus_if.bus_rdy_ = 1'b0;
      tick();
      tick();
      check("rb_ignore_busy", 32'(busy), 32'd0);
      check("rb_ignore_out", out, 32'h77);
      check("rb_ignore_as", 32'(bus_if.bus_as_), 32'd1);
      bus_if.bus_rdy_ = 1'b1;

`ifdef MEM_BUS_TIMEOUT_EN
      begin
         int n = 0;
         ex_en = 1'b1; op = 4'd3; ex_out = 32'h400;
         tick();
         ex_en = 1'b0; ex_out = 32'd0;
         while (busy && n < 300) begin
            n++;
            tick();
         end
         check("tmo_cycles", n, 255);
         check("tmo_err", 32'(bus_err), 32'd1);
         check("tmo_out", out, 32'd0);
         check("tmo_busy", 32'(busy), 32'd0);
         tick();
         check("tmo_err_clr", 32'(bus_err), 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 clock; reset in 1, asynchronous, active-high.
REQ-002 SHALL have pipeline inputs:
  - ex_en in 1: EX/MEM data valid.
  - ex_mem_op in 4: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; others treated as NOP.
  - ex_out in 32: ALU result, used as the access address.
  - ex_mem_wr_data in 32: store data.
  - stall in 1: global stall.
  - flush in 1: global flush.
REQ-003 SHALL have bus ports:
  - bus_as_ out 1: address strobe, active-low.
  - bus_rw out 1: 1 read, 0 write.
  - bus_addr out 30: word address, ex_out[31:2].
  - bus_be out 4: byte enables.
  - bus_wr_data out 32: write data.
  - bus_rd_data in 32: read data.
  - bus_rdy_ in 1: ready, active-low.
REQ-004 SHALL have result outputs:
  - out out 32: result to MEM/WB register.
  - miss_align out 1: misalignment flag.
  - busy out 1: stall request.
  - bus_err out 1: timeout flag.

Function
REQ-005 SHALL implement FSM states IDLE, BUS and DONE.
REQ-006 Access request (acc) SHALL be: ex_en=1 & op in 1..8 & !miss_align & !flush.
REQ-007 miss_align SHALL be combinational and asserted only when ex_en=1, as follows:
  - LH, LHU, SH: asserted when ex_out[0]=1.
  - LW, SW: asserted when ex_out[1:0]!=0.
  - Byte ops: never asserted.
REQ-008 A misaligned access SHALL start no bus cycle, SHALL drive out=0, and SHALL leave busy=0.
REQ-009 IDLE, acc=1: SHALL register bus_addr, bus_rw, bus_be and bus_wr_data; SHALL go to BUS next cycle. busy=1 that cycle.
REQ-010 BUS: SHALL drive bus_as_=0 and busy=1.
  - When bus_rdy_=0, SHALL capture bus_rd_data into rd_buf and go to DONE.
REQ-011 DONE: SHALL drive busy=0 and out=formatted rd_buf (loads) or 0 (stores).
  - Stays in DONE while stall=1.
  - Goes to IDLE when stall=0.
REQ-012 IDLE with no acc and no misalignment: SHALL drive out=ex_out (passthrough).
REQ-013 Byte enables SHALL be little-endian by ex_out[1:0]:
  - Byte ops: be=1<<ex_out[1:0].
  - Half ops: be=4'b0011 or 4'b1100 by ex_out[1].
  - Word ops: be=4'b1111.
REQ-014 Store data SHALL be replicated across lanes: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
REQ-015 Load format SHALL select the lane by ex_out[1:0].
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
REQ-016 Flush in IDLE SHALL suppress the access.
REQ-017 Flush during BUS SHALL NOT abort the bus cycle. Instead:
  - A pending-discard bit is set and busy stays 1 until bus_rdy_=0.
  - The FSM then goes to IDLE (not DONE) and out=0.
REQ-018 bus_as_ SHALL be asserted only in BUS; outside BUS, bus_as_=1.
REQ-019 Back-to-back accesses SHALL each pay at least one IDLE cycle: minimum latency is 3 cycles (IDLE, BUS with zero-wait rdy, DONE).

Reset
REQ-020 Reset SHALL force the following, taking effect immediately and asynchronously:
  - State: IDLE.
  - Bus outputs: bus_as_=1, bus_rw=1, bus_addr=0, bus_be=0, bus_wr_data=0.
  - Internal registers: rd_buf=0, discard=0, timeout counter=0.
  - bus_err=0.
REQ-021 Reset during BUS SHALL abandon the cycle; a later bus_rdy_ SHALL be ignored.

Configuration
REQ-022 Macro MEM_BUS_TIMEOUT_EN defined:
  - An 8-bit counter SHALL clear on BUS entry and increment each BUS cycle.
  - If it reaches 255 with bus_rdy_=1, the FSM SHALL go to DONE with bus_err=1 and out=0.
  - bus_err SHALL clear on leaving DONE.
REQ-023 MEM_BUS_TIMEOUT_EN undefined: the counter SHALL be absent, bus_err SHALL be tied 0, and BUS SHALL wait indefinitely.

Verification
REQ-024 LW at 0x100, rdy_ zero-wait, rd_data 0xDEADBEEF -> busy=1 for 2 cycles, out=0xDEADBEEF in DONE, bus_be=4'b1111.
REQ-025 LB at 0x103, rd_data 0x80123456 -> out=0xFFFFFF80. LBU at the same address -> out=0x00000080.
REQ-026 SH at 0x102, data 0x0000ABCD -> bus_rw=0, bus_be=4'b1100, bus_wr_data=0xABCDABCD.
REQ-027 LW at 0x101 -> miss_align=1, out=0, bus_as_ stays 1, busy=0.
REQ-028 Flush asserted during BUS with rdy_ delayed 3 cycles -> busy held until rdy_, then IDLE, DONE skipped, out=0.
REQ-029 With MEM_BUS_TIMEOUT_EN and rdy_ never asserted -> after 255 BUS cycles, bus_err=1, out=0, busy=0.
